// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between the EX stage and alu_exec_unit.
//  slave  : the ALU side (drives o_ready and the result/flag signals)
//  master : the pipeline side (drives the request, operands, opcode and flush)
//  Signals: i_valid/o_ready request handshake, i_alu_opcode, i_data_a, i_data_b,
//           i_shamt, i_flush, o_valid result pulse, o_result, o_zero, o_overflow,
//           o_illegal.
interface alu_exec_unit_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_OP_FIELD = 6,
  parameter int NB_SHAMT    = 5
) ();
  logic                   i_valid;
  logic                   o_ready;
  logic [NB_OP_FIELD-1:0] i_alu_opcode;
  logic [NB_DATA-1:0]     i_data_a;
  logic [NB_DATA-1:0]     i_data_b;
  logic [NB_SHAMT-1:0]    i_shamt;
  logic                   i_flush;
  logic                   o_valid;
  logic [NB_DATA-1:0]     o_result;
  logic                   o_zero;
  logic                   o_overflow;
  logic                   o_illegal;

  modport slave (
    input  i_valid, i_alu_opcode, i_data_a, i_data_b, i_shamt, i_flush,
    output o_ready, o_valid, o_result, o_zero, o_overflow, o_illegal
  );

  modport master (
    output i_valid, i_alu_opcode, i_data_a, i_data_b, i_shamt, i_flush,
    input  o_ready, o_valid, o_result, o_zero, o_overflow, o_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution-stage ALU. Logic/arithmetic ops complete in one cycle;
// shifts use an iterative 1-bit-per-cycle shifter while o_ready is held low.
//  i_clk    : clock, rising edge
//  i_rst_n  : asynchronous active-low reset
//  bus      : alu_exec_unit_if.slave (request handshake, operands, flush, result + flags)
module alu_exec_unit #(
  parameter int NB_DATA     = 32,
  parameter int NB_OP_FIELD = 6,
  parameter int NB_SHAMT    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [NB_OP_FIELD-1:0] OP_ADD  = 6'b110001;
  localparam logic [NB_OP_FIELD-1:0] OP_ADDU = 6'b100001;
  localparam logic [NB_OP_FIELD-1:0] OP_SUBU = 6'b100011;
  localparam logic [NB_OP_FIELD-1:0] OP_AND  = 6'b100100;
  localparam logic [NB_OP_FIELD-1:0] OP_OR   = 6'b100101;
  localparam logic [NB_OP_FIELD-1:0] OP_XOR  = 6'b100110;
  localparam logic [NB_OP_FIELD-1:0] OP_NOR  = 6'b100111;
  localparam logic [NB_OP_FIELD-1:0] OP_SLT  = 6'b101010;
  localparam logic [NB_OP_FIELD-1:0] OP_LUI  = 6'b101011;
  localparam logic [NB_OP_FIELD-1:0] OP_SLL  = 6'b000000;
  localparam logic [NB_OP_FIELD-1:0] OP_SRL  = 6'b000010;
  localparam logic [NB_OP_FIELD-1:0] OP_SRA  = 6'b000011;
  localparam logic [NB_OP_FIELD-1:0] OP_SLLV = 6'b000100;
  localparam logic [NB_OP_FIELD-1:0] OP_SRLV = 6'b000110;
  localparam logic [NB_OP_FIELD-1:0] OP_SRAV = 6'b000111;

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shtype_t;

  state_t              state;
  shtype_t             sh_type;
  logic [NB_SHAMT-1:0] sh_cnt;
  logic [NB_DATA-1:0]  sh_data;
  logic [NB_DATA-1:0]  sh_next;

  logic                valid_r, zero_r, ovf_r, ill_r;
  logic [NB_DATA-1:0]  result_r;

  logic                accept;
  logic                is_shift;
  logic                var_shift;
  shtype_t             sh_type_in;
  logic [NB_SHAMT-1:0] amount;
  logic [NB_DATA-1:0]  comb_result;

  // Single-cycle result. Shift opcodes return b here, which is the n == 0 answer.
  function automatic logic [NB_DATA-1:0] alu_result(
    input logic [NB_OP_FIELD-1:0] op,
    input logic [NB_DATA-1:0]     a,
    input logic [NB_DATA-1:0]     b
  );
    logic signed [NB_DATA-1:0] sa;
    logic signed [NB_DATA-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD, OP_ADDU: alu_result = a + b;
      OP_SUBU:         alu_result = a - b;
      OP_AND:          alu_result = a & b;
      OP_OR:           alu_result = a | b;
      OP_XOR:          alu_result = a ^ b;
      OP_NOR:          alu_result = ~(a | b);
      OP_SLT:          alu_result = {{(NB_DATA-1){1'b0}}, (sa < sb)};
      OP_LUI:          alu_result = {b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
      OP_SLL, OP_SRL, OP_SRA,
      OP_SLLV, OP_SRLV, OP_SRAV: alu_result = b;
      default:         alu_result = '0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [NB_OP_FIELD-1:0] op);
    case (op)
      OP_ADD, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_LUI,
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // Signed overflow: operands share a sign that the wrapped sum does not.
  function automatic logic add_overflow(
    input logic signed [NB_DATA-1:0] a,
    input logic signed [NB_DATA-1:0] b
  );
    logic signed [NB_DATA-1:0] sum;
    sum = a + b;
    add_overflow = (a[NB_DATA-1] == b[NB_DATA-1]) && (sum[NB_DATA-1] != a[NB_DATA-1]);
  endfunction

  function automatic logic [NB_DATA-1:0] shift_one(
    input shtype_t            t,
    input logic [NB_DATA-1:0] v
  );
    case (t)
      SH_RL:   shift_one = {1'b0, v[NB_DATA-1:1]};
      SH_RA:   shift_one = {v[NB_DATA-1], v[NB_DATA-1:1]};
      default: shift_one = {v[NB_DATA-2:0], 1'b0};
    endcase
  endfunction

  always_comb begin
    is_shift   = 1'b0;
    var_shift  = 1'b0;
    sh_type_in = SH_LL;
    case (bus.i_alu_opcode)
      OP_SLL:  is_shift = 1'b1;
      OP_SRL:  begin is_shift = 1'b1; sh_type_in = SH_RL; end
      OP_SRA:  begin is_shift = 1'b1; sh_type_in = SH_RA; end
      OP_SLLV: begin is_shift = 1'b1; var_shift = 1'b1; end
      OP_SRLV: begin is_shift = 1'b1; var_shift = 1'b1; sh_type_in = SH_RL; end
      OP_SRAV: begin is_shift = 1'b1; var_shift = 1'b1; sh_type_in = SH_RA; end
      default: ;
    endcase
    amount = var_shift ? bus.i_data_a[NB_SHAMT-1:0] : bus.i_shamt;
  end

  // A flush in IDLE suppresses the accept for that cycle.
  assign accept      = bus.i_valid && (state == IDLE) && !bus.i_flush;
  assign comb_result = alu_result(bus.i_alu_opcode, bus.i_data_a, bus.i_data_b);
  assign sh_next     = shift_one(sh_type, sh_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sh_type  <= SH_LL;
      sh_cnt   <= '0;
      valid_r  <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (amount != '0)) begin
              sh_cnt  <= amount;
              sh_type <= sh_type_in;
              state   <= SHIFT;
            end else begin
              result_r <= comb_result;
              zero_r   <= (comb_result == '0);
              ovf_r    <= (bus.i_alu_opcode == OP_ADD) &&
                          add_overflow(bus.i_data_a, bus.i_data_b);
              ill_r    <= !op_legal(bus.i_alu_opcode);
              valid_r  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.i_flush) begin
            state <= IDLE;
          end else begin
            sh_cnt <= sh_cnt - 1'b1;
            // Last step: sh_next already holds the fully shifted value.
            if (sh_cnt == {{(NB_SHAMT-1){1'b0}}, 1'b1}) begin
              result_r <= sh_next;
              zero_r   <= (sh_next == '0);
              ovf_r    <= 1'b0;
              ill_r    <= 1'b0;
              valid_r  <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath register; content is only meaningful while in SHIFT.
  always_ff @(posedge i_clk) begin
    if (accept && is_shift)
      sh_data <= bus.i_data_b;
    else if (state == SHIFT)
      sh_data <= sh_next;
  end

  assign bus.o_ready    = (state == IDLE);
  assign bus.o_valid    = valid_r;
  assign bus.o_result   = result_r;
  assign bus.o_zero     = zero_r;
  assign bus.o_overflow = ovf_r;
  assign bus.o_illegal  = ill_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit. Directed vector table,
// hand-written multi-cycle sequences (back-to-back, flush, busy, async reset) and
// random operations checked against a behavioural model.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    bit          ovf;
    bit          ill;
    int          lat;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the opcode table.
  function automatic vec_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] shamt);
    vec_t m;
    longint s;
    int n;
    logic signed [31:0] sb;
    m.op = op; m.a = a; m.b = b; m.shamt = shamt;
    m.ovf = 0; m.ill = 0; m.lat = 1; m.res = '0;
    sb = b;
    n  = (op[2] == 1'b1) ? int'(a[4:0]) : int'(shamt);
    case (op)
      6'b110001: begin
        m.res = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100001: m.res = a + b;
      6'b100011: m.res = a - b;
      6'b100100: m.res = a & b;
      6'b100101: m.res = a | b;
      6'b100110: m.res = a ^ b;
      6'b100111: m.res = ~(a | b);
      6'b101010: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b101011: m.res = {b[15:0], 16'h0000};
      6'b000000, 6'b000100: begin m.res = b << n;  m.lat = n + 1; end
      6'b000010, 6'b000110: begin m.res = b >> n;  m.lat = n + 1; end
      6'b000011, 6'b000111: begin m.res = sb >>> n; m.lat = n + 1; end
      default: begin m.res = '0; m.ill = 1; end
    endcase
    return m;
  endfunction

  // Issue one op, wait for o_valid (bounded), check latency, busy time and outputs.
  task automatic run_op(input string name, input vec_t v);
    int k;
    int busy;
    bit got;
    @(negedge clk);
    bus.i_alu_opcode = v.op;
    bus.i_data_a     = v.a;
    bus.i_data_b     = v.b;
    bus.i_shamt      = v.shamt;
    bus.i_valid      = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    k = 1; busy = 0; got = 0;
    while (k <= 40 && !got) begin
      if (bus.o_valid) got = 1;
      else begin
        if (!bus.o_ready) busy++;
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no o_valid within 40 cycles, required latency %0d", name, v.lat);
    end else begin
      check({name, " latency"}, k, v.lat);
      check({name, " ready_low"}, busy, v.lat - 1);
      check({name, " result"}, bus.o_result, v.res);
      check({name, " zero"}, {31'd0, bus.o_zero}, {31'd0, (v.res == 32'd0)});
      check({name, " overflow"}, {31'd0, bus.o_overflow}, {31'd0, v.ovf});
      check({name, " illegal"}, {31'd0, bus.o_illegal}, {31'd0, v.ill});
    end
  endtask

  logic [5:0] legal_ops [15];
  int nvalid;

  initial begin
    vectors = 0;
    miscompares = 0;
    legal_ops = '{6'b110001, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000,
                  6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};

    vec[0]  = '{6'b110001, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1, 0, 1};
    vec[1]  = '{6'b000011, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000, 0, 0, 5};
    vec[2]  = '{6'b000110, 32'h00000025, 32'hF0000000, 5'd0, 32'h07800000, 0, 0, 6};
    vec[3]  = '{6'b000000, 32'h00000000, 32'h12345678, 5'd0, 32'h12345678, 0, 0, 1};
    vec[4]  = '{6'b111111, 32'h00000005, 32'h00000006, 5'd0, 32'h00000000, 0, 1, 1};
    vec[5]  = '{6'b100011, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 0, 0, 1};
    vec[6]  = '{6'b100111, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 0, 0, 1};
    vec[7]  = '{6'b101011, 32'h00000000, 32'h0000ABCD, 5'd0, 32'hABCD0000, 0, 0, 1};
    vec[8]  = '{6'b101010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 0, 0, 1};
    vec[9]  = '{6'b101010, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 0, 0, 1};
    vec[10] = '{6'b100001, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 0, 0, 1};
    vec[11] = '{6'b000100, 32'h0000003F, 32'h00000001, 5'd0, 32'h80000000, 0, 0, 32};

    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_alu_opcode = '0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_shamt = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, bus.o_ready}, 32'd1);
    check("reset valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset result", bus.o_result, 32'd0);
    check("reset flags", {29'd0, bus.o_zero, bus.o_overflow, bus.o_illegal}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op($sformatf("vec%0d", i), vec[i]);

    // Flags hold after the illegal result's pulse ends.
    run_op("illegal", model(6'b111111, 32'd1, 32'd2, 5'd0));
    @(negedge clk);
    check("illegal hold valid", {31'd0, bus.o_valid}, 32'd0);
    check("illegal hold flag", {31'd0, bus.o_illegal}, 32'd1);

    // Back-to-back AND, OR, SLT(-1,1).
    @(negedge clk);
    bus.i_alu_opcode = 6'b100100; bus.i_data_a = 32'hF0F0F0F0; bus.i_data_b = 32'hFF00FF00;
    bus.i_valid = 1'b1;
    @(negedge clk);
    check("b2b and valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2b and result", bus.o_result, 32'hF000F000);
    bus.i_alu_opcode = 6'b100101;
    @(negedge clk);
    check("b2b or valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2b or result", bus.o_result, 32'hFFF0FFF0);
    bus.i_alu_opcode = 6'b101010; bus.i_data_a = 32'hFFFFFFFF; bus.i_data_b = 32'h1;
    @(negedge clk);
    check("b2b slt valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2b slt result", bus.o_result, 32'd1);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("b2b end valid", {31'd0, bus.o_valid}, 32'd0);

    // Flush two cycles into SLL by 10, then an ADD is accepted at once.
    run_op("pre flush", model(6'b100001, 32'd3, 32'd4, 5'd0));
    @(negedge clk);
    bus.i_alu_opcode = 6'b000000; bus.i_data_b = 32'h1; bus.i_shamt = 5'd10;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("flush k1 valid", {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("flush ready", {31'd0, bus.o_ready}, 32'd1);
    check("flush valid", {31'd0, bus.o_valid}, 32'd0);
    check("flush result held", bus.o_result, 32'd7);
    bus.i_alu_opcode = 6'b110001; bus.i_data_a = 32'd10; bus.i_data_b = 32'd20;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("post flush add valid", {31'd0, bus.o_valid}, 32'd1);
    check("post flush add result", bus.o_result, 32'd30);
    nvalid = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_valid) nvalid++;
    end
    check("flushed shift silent", nvalid, 0);

    // Flush in IDLE blocks the accept.
    bus.i_alu_opcode = 6'b110001; bus.i_data_a = 32'd5; bus.i_data_b = 32'd5;
    bus.i_valid = 1'b1; bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    check("idle flush valid", {31'd0, bus.o_valid}, 32'd0);
    check("idle flush result", bus.o_result, 32'd30);

    // i_valid while busy is ignored.
    bus.i_alu_opcode = 6'b000010; bus.i_data_b = 32'h80000000; bus.i_shamt = 5'd3;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_alu_opcode = 6'b110001; bus.i_data_a = 32'd1; bus.i_data_b = 32'd1;
    @(negedge clk);
    @(negedge clk);
    check("busy ready", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("busy srl valid", {31'd0, bus.o_valid}, 32'd1);
    check("busy srl result", bus.o_result, 32'h10000000);
    @(negedge clk);
    check("busy no extra valid", {31'd0, bus.o_valid}, 32'd0);
    check("busy result held", bus.o_result, 32'h10000000);

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 14)];
      run_op($sformatf("rand%0d op%b", i, op),
             model(op, $urandom, $urandom, 5'($urandom_range(0, 31))));
    end

    // Async reset in the middle of a shift.
    run_op("pre reset", model(6'b100001, 32'd1, 32'd1, 5'd0));
    @(negedge clk);
    bus.i_alu_opcode = 6'b000000; bus.i_data_b = 32'h1; bus.i_shamt = 5'd20;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst ready", {31'd0, bus.o_ready}, 32'd1);
    check("async rst valid", {31'd0, bus.o_valid}, 32'd0);
    check("async rst result", bus.o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_valid) nvalid++;
    end
    check("reset op lost", nvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
